// File: rtl/tinymips_pkg.sv
// Shared encodings for the tinymips data-memory arbiter: FSM states and
// the identity of the requester that owns a transfer.
package tinymips_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_PRG   = 2'd2;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_MON = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one data_memory port between the CPU and the monitor, with
// round-robin arbitration and an exclusive program mode for the monitor.
module dmem_arbiter
  import tinymips_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wd,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rd,
  input  logic          mon_req,
  input  logic          mon_we,
  input  logic [AW-1:0] mon_addr,
  input  logic [DW-1:0] mon_wd,
  output logic          mon_gnt,
  output logic          mon_rvalid,
  output logic [DW-1:0] mon_rd,
  input  logic          mon_lock,
  output logic          lock_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          last_owner;
  logic          rv_valid;
  logic          rv_owner;
  logic [DW-1:0] rv_data;
  logic          read_gnt;
  logic          cpu_read_gnt;

  // Grants are gated by reset_n so every output is 0 while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    mon_gnt = 1'b0;
    if (reset_n) begin
      case (state)
        ST_RUN: begin
          if (cpu_req && mon_req) begin
            cpu_gnt = (last_owner == OWNER_MON);
            mon_gnt = (last_owner == OWNER_CPU);
          end else begin
            cpu_gnt = cpu_req;
            mon_gnt = mon_req;
          end
        end
        ST_PRG:  mon_gnt = mon_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end else if (mon_gnt) begin
      mem_we   = mon_we;
      mem_addr = mon_addr;
      mem_wd   = mon_wd;
    end
  end

  assign cpu_read_gnt = cpu_gnt && !cpu_we;
  assign read_gnt     = cpu_read_gnt || (mon_gnt && !mon_we);

  // A CPU read issued as the lock arrives gets one DRAIN cycle to return.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (mon_lock) state_nxt = cpu_read_gnt ? ST_DRAIN : ST_PRG;
      ST_DRAIN: state_nxt = mon_lock ? ST_PRG : ST_RUN;
      ST_PRG:   if (!mon_lock) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      last_owner <= OWNER_MON;
      rv_valid   <= 1'b0;
      rv_owner   <= OWNER_CPU;
      rv_data    <= '0;
    end else begin
      state    <= state_nxt;
      rv_valid <= read_gnt;
      if (cpu_gnt) begin
        last_owner <= OWNER_CPU;
      end else if (mon_gnt) begin
        last_owner <= OWNER_MON;
      end
      if (read_gnt) begin
        rv_owner <= cpu_gnt ? OWNER_CPU : OWNER_MON;
        rv_data  <= mem_rd;
      end
    end
  end

  assign cpu_rvalid = rv_valid && (rv_owner == OWNER_CPU);
  assign mon_rvalid = rv_valid && (rv_owner == OWNER_MON);
  assign cpu_rd     = cpu_rvalid ? rv_data : '0;
  assign mon_rd     = mon_rvalid ? rv_data : '0;
  assign lock_ack   = (state == ST_PRG);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter, checked against a
// behavioural model of the arbitration rules and a small backing memory.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wd = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rd;
  logic          mon_req = 1'b0, mon_we = 1'b0;
  logic [AW-1:0] mon_addr = '0;
  logic [DW-1:0] mon_wd = '0;
  logic          mon_gnt, mon_rvalid;
  logic [DW-1:0] mon_rd;
  logic          mon_lock = 1'b0;
  logic          lock_ack, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
    .mon_req(mon_req), .mon_we(mon_we), .mon_addr(mon_addr), .mon_wd(mon_wd),
    .mon_gnt(mon_gnt), .mon_rvalid(mon_rvalid), .mon_rd(mon_rd),
    .mon_lock(mon_lock), .lock_ack(lock_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  logic [31:0] bmem [0:255];
  assign mem_rd = bmem[mem_addr[7:0]];

  int compared = 0;
  int mismatched = 0;

  // Model: program mode, drain cycle, tie preference and one pending read.
  bit          m_prg, m_drain, m_cpu_first, m_rv, m_rv_cpu;
  logic [31:0] m_rv_data;

  task automatic modelReset();
    m_prg = 0; m_drain = 0; m_cpu_first = 1; m_rv = 0; m_rv_cpu = 0; m_rv_data = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutputBit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                               input logic [31:0] c_wd, input logic m_req, input logic m_we,
                               input logic [7:0] m_addr, input logic [31:0] m_wd, input logic lock);
    @(negedge clk);
    cpu_req = c_req; cpu_we = c_we; cpu_addr = {24'b0, c_addr}; cpu_wd = c_wd;
    mon_req = m_req; mon_we = m_we; mon_addr = {24'b0, m_addr}; mon_wd = m_wd;
    mon_lock = lock;
    #1;
  endtask

  // Compare every output to the model, then step the model across the next edge.
  task automatic checkAll();
    logic e_cg, e_mg, e_we, e_crv, e_mrv;
    logic [31:0] e_addr, e_wd, e_crd, e_mrd;
    if (!reset_n) modelReset();
    e_cg = 0; e_mg = 0;
    if (reset_n) begin
      if (m_prg) begin
        e_mg = mon_req;
      end else if (!m_drain) begin
        if (cpu_req && mon_req) begin
          e_cg = m_cpu_first; e_mg = !m_cpu_first;
        end else begin
          e_cg = cpu_req; e_mg = mon_req;
        end
      end
    end
    e_we   = e_cg ? cpu_we : (e_mg ? mon_we : 1'b0);
    e_addr = e_cg ? cpu_addr : (e_mg ? mon_addr : 32'h0);
    e_wd   = e_cg ? cpu_wd : (e_mg ? mon_wd : 32'h0);
    e_crv  = m_rv && m_rv_cpu;
    e_mrv  = m_rv && !m_rv_cpu;
    e_crd  = e_crv ? m_rv_data : 32'h0;
    e_mrd  = e_mrv ? m_rv_data : 32'h0;
    checkOutputBit("cpu_gnt", cpu_gnt, e_cg);
    checkOutputBit("mon_gnt", mon_gnt, e_mg);
    checkOutputBit("mem_we", mem_we, e_we);
    checkOutput("mem_addr", mem_addr, e_addr);
    checkOutput("mem_wd", mem_wd, e_wd);
    checkOutputBit("cpu_rvalid", cpu_rvalid, e_crv);
    checkOutput("cpu_rd", cpu_rd, e_crd);
    checkOutputBit("mon_rvalid", mon_rvalid, e_mrv);
    checkOutput("mon_rd", mon_rd, e_mrd);
    checkOutputBit("lock_ack", lock_ack, m_prg);
    if (reset_n) begin
      m_rv      = (e_cg && !cpu_we) || (e_mg && !mon_we);
      m_rv_cpu  = e_cg;
      m_rv_data = bmem[e_cg ? cpu_addr[7:0] : mon_addr[7:0]];
      if (e_cg) m_cpu_first = 0;
      else if (e_mg) m_cpu_first = 1;
      if (m_prg) begin
        m_prg = mon_lock;
      end else if (m_drain) begin
        m_drain = 0; m_prg = mon_lock;
      end else if (mon_lock) begin
        if (e_cg && !cpu_we) m_drain = 1;
        else m_prg = 1;
      end
      if (mem_we) bmem[mem_addr[7:0]] = mem_wd;
    end
  endtask

  task automatic runCycle(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                          input logic [31:0] c_wd, input logic m_req, input logic m_we,
                          input logic [7:0] m_addr, input logic [31:0] m_wd, input logic lock);
    applyStimulus(c_req, c_we, c_addr, c_wd, m_req, m_we, m_addr, m_wd, lock);
    checkAll();
  endtask

  // Reset lands mid-cycle with requests still asserted; they are dropped afterwards.
  task automatic pulseReset();
    #2;
    reset_n = 1'b0;
    #1;
    checkAll();
    cpu_req = 0; mon_req = 0; mon_lock = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) bmem[i] = $urandom;
    bmem[8'h10] = 32'hDEADBEEF;
    modelReset();
    $display("[TB] start");

    #2;
    checkAll();
    @(negedge clk);
    reset_n = 1'b1;

    // CPU-only read of 0x10.
    runCycle(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    checkOutputBit("s1_cpu_gnt", cpu_gnt, 1'b1);
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s1_cpu_rd", cpu_rd, 32'hDEADBEEF);
    checkOutputBit("s1_cpu_rvalid", cpu_rvalid, 1'b1);
    checkOutput("s1_mon_rd", mon_rd, 32'h0);

    // Simultaneous requests after reset alternate CPU first.
    runCycle(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    pulseReset();
    for (int k = 0; k < 4; k++) begin
      runCycle(1, 0, 8'h40, 0, 1, 0, 8'h41, 0, 0);
      checkOutputBit("s2_cpu_gnt", cpu_gnt, (k % 2) == 0);
      checkOutputBit("s2_mon_gnt", mon_gnt, (k % 2) == 1);
    end
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lock arrives with a CPU read: drain, then program mode.
    runCycle(1, 0, 8'h10, 0, 0, 0, 0, 0, 1);
    checkOutputBit("s3_cpu_gnt", cpu_gnt, 1'b1);
    runCycle(1, 0, 8'h30, 0, 0, 0, 0, 0, 1);
    checkOutputBit("s3_drain_cpu_gnt", cpu_gnt, 1'b0);
    checkOutput("s3_drain_cpu_rd", cpu_rd, 32'hDEADBEEF);
    checkOutputBit("s3_drain_lock_ack", lock_ack, 1'b0);
    runCycle(1, 0, 8'h30, 0, 1, 1, 8'h20, 32'h12345678, 1);
    checkOutputBit("s3_prg_lock_ack", lock_ack, 1'b1);
    checkOutputBit("s3_prg_cpu_gnt", cpu_gnt, 1'b0);
    checkOutputBit("s4_mem_we", mem_we, 1'b1);
    runCycle(1, 0, 8'h30, 0, 1, 0, 8'h20, 0, 1);
    checkOutputBit("s4_read_mem_we", mem_we, 1'b0);
    checkOutputBit("s4_read_mon_gnt", mon_gnt, 1'b1);

    // Lock drops while the CPU is still requesting.
    runCycle(1, 0, 8'h30, 0, 0, 0, 0, 0, 0);
    checkOutput("s4_mon_rd", mon_rd, 32'h12345678);
    checkOutputBit("s4_mon_rvalid", mon_rvalid, 1'b1);
    runCycle(1, 0, 8'h30, 0, 0, 0, 0, 0, 0);
    checkOutputBit("s5_lock_ack", lock_ack, 1'b0);
    checkOutputBit("s5_cpu_gnt", cpu_gnt, 1'b1);

    // One-cycle lock pulse still visits program mode.
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    runCycle(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    checkOutputBit("s7_pulse_lock_ack", lock_ack, 1'b1);
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-read discards the return.
    runCycle(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
    pulseReset();
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutputBit("s6_cpu_rvalid", cpu_rvalid, 1'b0);

    // Randomized traffic with a sticky lock and rare resets.
    for (int n = 0; n < 500; n++) begin
      r = $urandom;
      applyStimulus(r[0] | r[1], r[2], r[15:8], $urandom, r[3] | r[4], r[5], r[23:16], $urandom,
                    (r[30:28] == 3'b000) ? ~mon_lock : mon_lock);
      checkAll();
      if (r[31:26] == 6'd0) pulseReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
